// File: rtl/ball_motion_ctrl.sv
// Ball centre motion sequencer: once per frame, during vertical blanking,
// steps the ball centre by a programmable amount and reflects its direction
// off the visible-area walls. Centre registers only change in blanking.
module ball_motion_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int RADIUS   = 16,
    parameter int H_START  = 320,
    parameter int V_START  = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] Hcounter,
    input  logic [9:0] Vcounter,
    input  logic       enable,
    input  logic [2:0] speed,
    output logic [9:0] Hcentre,
    output logic [9:0] Vcentre,
    output logic       bounce_x,
    output logic       bounce_y,
    output logic       frame_tick
);

    localparam logic [2:0] WAIT_VBLANK = 3'd0;
    localparam logic [2:0] CALC_X      = 3'd1;
    localparam logic [2:0] CALC_Y      = 3'd2;
    localparam logic [2:0] COMMIT      = 3'd3;
    localparam logic [2:0] WAIT_ACTIVE = 3'd4;

    localparam logic signed [10:0] XMIN = 11'(RADIUS);
    localparam logic signed [10:0] XMAX = 11'(H_ACTIVE - 1 - RADIUS);
    localparam logic signed [10:0] YMIN = 11'(RADIUS);
    localparam logic signed [10:0] YMAX = 11'(V_ACTIVE - 1 - RADIUS);
    localparam logic [9:0]         VLIM   = 10'(V_ACTIVE);
    localparam logic [9:0]         H_INIT = 10'(H_START);
    localparam logic [9:0]         V_INIT = 10'(V_START);

    // Direction encoding: 1 = increasing coordinate, 0 = decreasing.
    logic [2:0] state;
    logic [2:0] step;
    logic       en_l;
    logic       dir_x, dir_y;
    logic [9:0] nx, ny;
    logic       ndx, ndy;
    logic       bx, by;
    logic [11:0] calc_x, calc_y;

    // The centre only moves in vertical blanking, so the column is not needed.
    logic unused_hcounter;
    assign unused_hcounter = ^Hcounter;

    // One axis step in 11-bit signed arithmetic; reaching a wall clamps and
    // reverses. Result packs {bounce, new_dir, new_pos}.
    function automatic logic [11:0] axis_step(
        input logic [9:0]         pos,
        input logic               dir,
        input logic [2:0]         stp,
        input logic signed [10:0] lo,
        input logic signed [10:0] hi
    );
        logic signed [10:0] ext;
        logic signed [10:0] sum;
        ext = $signed({8'd0, stp});
        sum = dir ? ($signed({1'b0, pos}) + ext) : ($signed({1'b0, pos}) - ext);
        if (dir && (sum >= hi)) begin
            axis_step = {1'b1, 1'b0, hi[9:0]};
        end else if (!dir && (sum <= lo)) begin
            axis_step = {1'b1, 1'b1, lo[9:0]};
        end else begin
            axis_step = {1'b0, dir, sum[9:0]};
        end
    endfunction

    // Candidate next position/direction for both axes from the current centre.
    always_comb begin
        calc_x = axis_step(Hcentre, dir_x, step, XMIN, XMAX);
        calc_y = axis_step(Vcentre, dir_y, step, YMIN, YMAX);
    end

    // Frame sequencer: capture controls at vblank start, compute X then Y,
    // commit once, then wait for the active region before re-arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_VBLANK;
            Hcentre    <= H_INIT;
            Vcentre    <= V_INIT;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            step       <= '0;
            en_l       <= 1'b0;
            nx         <= H_INIT;
            ny         <= V_INIT;
            ndx        <= 1'b1;
            ndy        <= 1'b1;
            bx         <= 1'b0;
            by         <= 1'b0;
            bounce_x   <= 1'b0;
            bounce_y   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            bounce_x   <= 1'b0;
            bounce_y   <= 1'b0;
            frame_tick <= 1'b0;
            case (state)
                WAIT_VBLANK: begin
                    if (Vcounter >= VLIM) begin
                        step  <= speed;
                        en_l  <= enable;
                        state <= CALC_X;
                    end
                end
                CALC_X: begin
                    {bx, ndx, nx} <= calc_x;
                    state         <= CALC_Y;
                end
                CALC_Y: begin
                    {by, ndy, ny} <= calc_y;
                    state         <= COMMIT;
                end
                COMMIT: begin
                    frame_tick <= 1'b1;
                    if (en_l) begin
                        Hcentre  <= nx;
                        Vcentre  <= ny;
                        dir_x    <= ndx;
                        dir_y    <= ndy;
                        bounce_x <= bx;
                        bounce_y <= by;
                    end
                    state <= WAIT_ACTIVE;
                end
                WAIT_ACTIVE: begin
                    if (Vcounter < VLIM) begin
                        state <= WAIT_VBLANK;
                    end
                end
                default: state <= WAIT_VBLANK;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl. Two instances share stimulus:
// the default one and one started lower on the screen so that both axes reach
// the bottom-right corner in the same frame.
module tb_ball_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hcnt, vcnt;
    logic       enable;
    logic [2:0] speed;
    logic [9:0] hc [2];
    logic [9:0] vc [2];
    logic       bx [2];
    logic       by [2];
    logic       ft [2];

    always #5 clk = ~clk;

    ball_motion_ctrl dut (
        .clk(clk), .rst(rst), .Hcounter(hcnt), .Vcounter(vcnt),
        .enable(enable), .speed(speed),
        .Hcentre(hc[0]), .Vcentre(vc[0]),
        .bounce_x(bx[0]), .bounce_y(by[0]), .frame_tick(ft[0])
    );

    ball_motion_ctrl #(.V_START(160)) dut_c (
        .clk(clk), .rst(rst), .Hcounter(hcnt), .Vcounter(vcnt),
        .enable(enable), .speed(speed),
        .Hcentre(hc[1]), .Vcentre(vc[1]),
        .bounce_x(bx[1]), .bounce_y(by[1]), .frame_tick(ft[1])
    );

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       bx;
        logic       by;
    } exp_t;

    typedef struct {
        int spd;
        bit en;
        int h0, v0;
        bit bx0, by0;
        int h1, v1;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last [2];
    exp_t mon_e;
    int   ticks [2];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (1 = moving towards larger coordinate).
    int mh [2];
    int mv [2];
    bit mdx [2];
    bit mdy [2];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic model_axis(input int pos, input bit dir, input int stp,
                              input int lo, input int hi,
                              output int np, output bit nd, output bit b);
        int t;
        t = dir ? pos + stp : pos - stp;
        if (dir && t >= hi) begin
            np = hi; nd = 1'b0; b = 1'b1;
        end else if (!dir && t <= lo) begin
            np = lo; nd = 1'b1; b = 1'b1;
        end else begin
            np = t; nd = dir; b = 1'b0;
        end
    endtask

    task automatic model_reset();
        mh[0] = 320; mv[0] = 240;
        mh[1] = 320; mv[1] = 160;
        for (int i = 0; i < 2; i++) begin
            mdx[i] = 1'b1;
            mdy[i] = 1'b1;
        end
    endtask

    task automatic model_frame(input int spd, input bit en);
        for (int i = 0; i < 2; i++) begin
            int   nh, nv;
            bit   ndx, ndy, bxx, byy;
            exp_t e;
            model_axis(mh[i], mdx[i], spd, 16, 623, nh, ndx, bxx);
            model_axis(mv[i], mdy[i], spd, 16, 463, nv, ndy, byy);
            if (en) begin
                mh[i] = nh; mv[i] = nv; mdx[i] = ndx; mdy[i] = ndy;
                e = '{10'(nh), 10'(nv), bxx, byy};
            end else begin
                e = '{10'(mh[i]), 10'(mv[i]), 1'b0, 1'b0};
            end
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Scoreboard: pop the expected commit on every frame_tick; bounce pulses
    // outside a commit are errors.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ft[i]) begin
                ticks[i]++;
                last[i] = '{hc[i], vc[i], bx[i], by[i]};
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_tick[%0d]: got tick expected none", i);
                end else begin
                    mon_e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("sb_h[%0d]", i), int'(hc[i]), int'(mon_e.h));
                    chk($sformatf("sb_v[%0d]", i), int'(vc[i]), int'(mon_e.v));
                    chk($sformatf("sb_bx[%0d]", i), int'(bx[i]), int'(mon_e.bx));
                    chk($sformatf("sb_by[%0d]", i), int'(by[i]), int'(mon_e.by));
                end
            end else if (bx[i] || by[i]) begin
                checks++;
                errors++;
                $display("FAIL stray_bounce[%0d]: got bx=%0d by=%0d expected 0 0",
                         i, bx[i], by[i]);
            end
        end
    end

    // One frame: raise Vcounter into blanking for 'dwell' clocks, scramble the
    // controls after the capture edge, then return to the active region.
    task automatic frame(input int spd, input bit en, input int dwell);
        int lat;
        lat = -1;
        speed  = 3'(spd);
        enable = en;
        vcnt   = 10'd480;
        model_frame(spd, en);
        for (int c = 1; c <= dwell; c++) begin
            @(negedge clk);
            if (c == 1) begin
                speed  = 3'($urandom);
                enable = 1'($urandom);
            end
            if (ft[0] && lat < 0) lat = c;
        end
        vcnt = 10'd100;
        repeat (3) @(negedge clk);
        chk("latency", lat, 4);
        chk("tick_arrived", q0.size() + q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    task automatic chk_last(input string nm, input int i, input int h, input int v,
                            input int b_x, input int b_y);
        chk({nm, "_h"}, int'(last[i].h), h);
        chk({nm, "_v"}, int'(last[i].v), v);
        chk({nm, "_bx"}, int'(last[i].bx), b_x);
        chk({nm, "_by"}, int'(last[i].by), b_y);
    endtask

    vec_t tbl [6];
    int   t0;

    initial begin
        tbl[0] = '{4, 1'b1, 324, 244, 1'b0, 1'b0, 324, 164};
        tbl[1] = '{7, 1'b1, 331, 251, 1'b0, 1'b0, 331, 171};
        tbl[2] = '{0, 1'b1, 331, 251, 1'b0, 1'b0, 331, 171};
        tbl[3] = '{7, 1'b0, 331, 251, 1'b0, 1'b0, 331, 171};
        tbl[4] = '{7, 1'b1, 338, 258, 1'b0, 1'b0, 338, 178};
        tbl[5] = '{1, 1'b1, 339, 259, 1'b0, 1'b0, 339, 179};

        ticks[0] = 0; ticks[1] = 0;
        rst = 1'b1; hcnt = '0; vcnt = '0; enable = 1'b0; speed = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_h", int'(hc[0]), 320);
        chk("rst_v", int'(vc[0]), 240);
        chk("rst_tick", int'(ft[0]), 0);
        chk("rst_bounce", int'(bx[0]) + int'(by[0]), 0);
        chk("rst_c_h", int'(hc[1]), 320);
        chk("rst_c_v", int'(vc[1]), 160);

        // Table: basic stepping, speed 0 and a frozen frame.
        for (int k = 0; k < 6; k++) begin
            frame(tbl[k].spd, tbl[k].en, 4);
            chk_last($sformatf("tbl%0d", k), 0, tbl[k].h0, tbl[k].v0,
                     int'(tbl[k].bx0), int'(tbl[k].by0));
            chk($sformatf("tbl%0d_c_h", k), int'(last[1].h), tbl[k].h1);
            chk($sformatf("tbl%0d_c_v", k), int'(last[1].v), tbl[k].v1);
        end

        // Walk right to 621 (main) and 621/461 (corner instance).
        repeat (40) frame(7, 1'b1, 4);
        frame(2, 1'b1, 4);
        chk_last("pre", 0, 621, 391, 0, 0);
        chk_last("pre_c", 1, 621, 461, 0, 0);
        frame(4, 1'b1, 4);
        chk_last("xwall", 0, 623, 387, 1, 0);
        chk_last("corner", 1, 623, 463, 1, 1);
        @(negedge clk);
        frame(4, 1'b1, 4);
        chk_last("after_x", 0, 619, 383, 0, 0);
        chk_last("after_c", 1, 619, 459, 0, 0);

        // Counter stall in blanking: exactly one commit.
        t0 = ticks[0];
        frame(3, 1'b1, 5000);
        chk("stall_ticks", ticks[0] - t0, 1);
        chk_last("stall", 0, 616, 380, 0, 0);

        // Frozen frame, then resume at speed 7.
        t0 = ticks[0];
        frame(7, 1'b0, 4);
        chk("frozen_tick", ticks[0] - t0, 1);
        chk_last("frozen", 0, 616, 380, 0, 0);
        frame(7, 1'b1, 4);
        chk_last("resume", 0, 609, 373, 0, 0);
        chk_last("resume_c", 1, 609, 449, 0, 0);

        // Reset while the FSM is in CALC_Y: frame is discarded.
        t0 = ticks[0];
        speed = 3'd4; enable = 1'b1; vcnt = 10'd480;
        repeat (2) @(negedge clk);
        rst = 1'b1; vcnt = 10'd100;
        @(negedge clk);
        chk("midrst_h", int'(hc[0]), 320);
        chk("midrst_v", int'(vc[0]), 240);
        chk("midrst_pulses", int'(ft[0]) + int'(bx[0]) + int'(by[0]), 0);
        chk("midrst_c_v", int'(vc[1]), 160);
        rst = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
        chk("midrst_no_commit", ticks[0] - t0, 0);
        frame(4, 1'b1, 4);
        chk_last("post_rst", 0, 324, 244, 0, 0);
        chk_last("post_rst_c", 1, 324, 164, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
